pipe_stage_skid: RTL

Parametrised, elastic successor to the fixed decode-to-execute pipeline register. It carries one instruction's payload between two pipeline stages with a valid/ready handshake, a 2-entry skid buffer, a flush that inserts a bubble, and a saturating T_new countdown. Stalls no longer freeze the upstream stage combinationally. It sits between any pair of stages (D→E, E→M, M→W) and is instantiated once per boundary with stage-specific widths.

---
 rtl/pipe_stage_skid.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline register with a 2-entry skid buffer, flush-to-bubble and saturating T_new decrement.
// Latency: 1 cycle from accepted input to out_valid; 1 instruction/cycle sustained throughput.
// Backpressure: in_ready is decoded from registered state only (low while the skid entry is full); out_* are registered.
module pipe_stage_skid #(
  parameter int PAYLOAD_W = 160,
  parameter int TNEW_W    = 2,
  parameter int TNEW_DEC  = 1,
  parameter int ADDR_W    = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic [TNEW_W-1:0]    in_tnew,
  input  logic                 in_regwrite,
  input  logic [ADDR_W-1:0]    in_waddr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [TNEW_W-1:0]    out_tnew,
  output logic                 out_regwrite,
  output logic [ADDR_W-1:0]    out_waddr,
  output logic [1:0]           occupancy
);

  typedef struct packed {
    logic [PAYLOAD_W-1:0] payload;
    logic [TNEW_W-1:0]    tnew;
    logic                 regwrite;
    logic [ADDR_W-1:0]    waddr;
  } entry_t;

  // Entry valid bits are implied by the state: M valid unless EMPTY, S valid only in FULL.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t state_q, state_d;
  entry_t m_q, m_d;
  entry_t s_q, s_d;
  entry_t in_entry;
  logic   acc_in;
  logic   acc_out;

  // Saturating subtract evaluated at 32 bits so TNEW_DEC may exceed the field range.
  function automatic logic [TNEW_W-1:0] cap_tnew(input logic [TNEW_W-1:0] t);
    logic [31:0] t_ext;
    t_ext = 32'(t);
    if (t_ext > 32'(TNEW_DEC)) begin
      cap_tnew = TNEW_W'(t_ext - 32'(TNEW_DEC));
    end else begin
      cap_tnew = '0;
    end
  endfunction

  always_comb begin
    in_entry          = '0;
    in_entry.payload  = in_payload;
    in_entry.tnew     = cap_tnew(in_tnew);
    in_entry.regwrite = in_regwrite;
    in_entry.waddr    = in_waddr;
  end

  assign acc_in  = in_valid & in_ready;
  assign acc_out = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      m_q     <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (acc_in) state_d = ST_ONE;
      ST_ONE: begin
        if (acc_out && !acc_in)      state_d = ST_EMPTY;
        else if (!acc_out && acc_in) state_d = ST_FULL;
      end
      ST_FULL:  if (acc_out) state_d = ST_ONE;
      default:  state_d = ST_EMPTY;
    endcase
    if (flush) state_d = ST_EMPTY;
  end

  // Vacated entries are zeroed so hazard logic can read out_* without gating on out_valid.
  always_comb begin
    m_d = m_q;
    s_d = s_q;
    case (state_q)
      ST_EMPTY: if (acc_in) m_d = in_entry;
      ST_ONE: begin
        if (acc_out) begin
          m_d = acc_in ? in_entry : '0;
        end else if (acc_in) begin
          s_d = in_entry;
        end
      end
      ST_FULL: begin
        if (acc_out) begin
          m_d = s_q;
          s_d = '0;
        end
      end
      default: begin
        m_d = '0;
        s_d = '0;
      end
    endcase
    if (flush) begin
      m_d = '0;
      s_d = '0;
    end
  end

  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    occupancy = 2'd0;
    case (state_q)
      ST_ONE: begin
        out_valid = 1'b1;
        occupancy = 2'd1;
      end
      ST_FULL: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        occupancy = 2'd2;
      end
      default: ;
    endcase
  end

  assign out_payload  = m_q.payload;
  assign out_tnew     = m_q.tnew;
  assign out_regwrite = m_q.regwrite;
  assign out_waddr    = m_q.waddr;

endmodule
